param_shift_engine: RTL and testbench

- Parametrised multi-mode shift engine; next generation of the team's 8-bit load/shift/rotate register.
- Adds configurable WIDTH, a multi-position shift sequencer (one position per clock) with start/busy/done handshake, abort, and an arithmetic-right mode.
- Sits between a host/control FSM and serial links or datapath units that need N-bit serialisation, rotation or scaling without a barrel shifter.

---
 rtl/param_shift_engine_if.sv | 43 ++++
 rtl/param_shift_engine.sv | 139 +++++++++++++
 tb/tb_param_shift_engine.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_shift_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : param_shift_engine_if
// Purpose  : Host-side control/data bundle for param_shift_engine.
//            master = host / control FSM, slave = shift engine.
// Signals  : p_load/p_data   parallel load request and value
//            start/dir/mode/amount  job request (latched by engine)
//            s_in            serial fill bit for logical shifts
//            abort           terminate an in-flight job
//            p_out/s_out     data register and next shifted-out bit
//            busy/done       job status (busy in SHIFT, done one cycle)
//            remaining       steps still to perform
// Revision : 1.0 - initial release
// ============================================================================
interface param_shift_engine_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic             p_load;
  logic [WIDTH-1:0] p_data;
  logic             start;
  logic             dir;
  logic [1:0]       mode;
  logic [CNT_W-1:0] amount;
  logic             s_in;
  logic             abort;
  logic [WIDTH-1:0] p_out;
  logic             s_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;

  modport master (
    output p_load, p_data, start, dir, mode, amount, s_in, abort,
    input  p_out, s_out, busy, done, remaining
  );

  modport slave (
    input  p_load, p_data, start, dir, mode, amount, s_in, abort,
    output p_out, s_out, busy, done, remaining
  );
endinterface
`default_nettype wire

// File: rtl/param_shift_engine.sv
`default_nettype none
// ============================================================================
// Module   : param_shift_engine
// Purpose  : Parametrised load/shift/rotate register with a one-position-
//            per-clock step sequencer (IDLE -> SHIFT -> DONE), abort, and
//            logical / rotate / arithmetic / hold modes.
// Ports    : clk    rising-edge clock
//            reset  synchronous, active-high reset
//            bus    param_shift_engine_if.slave (see interface file)
// Revision : 1.0 - initial release
// ============================================================================
module param_shift_engine #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  wire logic            clk,
  input  wire logic            reset,
  param_shift_engine_if.slave  bus
);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_SHIFT = 2'd1;
  localparam logic [1:0] c_S_DONE  = 2'd2;

  localparam logic [1:0] c_MODE_LOG = 2'b00;
  localparam logic [1:0] c_MODE_ROT = 2'b01;
  localparam logic [1:0] c_MODE_ARI = 2'b10;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_rem;
  logic             r_dir;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] w_step;
  logic             w_dir_eff;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: begin
        // A load in the same cycle as start wins and the start is dropped.
        if (!bus.p_load && bus.start) begin
          w_state_nxt = (bus.amount != '0) ? c_S_SHIFT : c_S_DONE;
        end
      end
      c_S_SHIFT: begin
        if (bus.abort) begin
          w_state_nxt = c_S_IDLE;
        end else if (r_rem <= CNT_W'(1)) begin
          w_state_nxt = c_S_DONE;
        end
      end
      c_S_DONE:  w_state_nxt = c_S_IDLE;
      default:   w_state_nxt = c_S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Single-position step of the data register using the latched job settings.
  // Left arithmetic is a plain zero-filling shift.
  // --------------------------------------------------------------------------
  always_comb begin
    w_step = r_data;
    case (r_mode)
      c_MODE_LOG: w_step = r_dir ? {bus.s_in, r_data[WIDTH-1:1]}
                                 : {r_data[WIDTH-2:0], bus.s_in};
      c_MODE_ROT: w_step = r_dir ? {r_data[0], r_data[WIDTH-1:1]}
                                 : {r_data[WIDTH-2:0], r_data[WIDTH-1]};
      c_MODE_ARI: w_step = r_dir ? {r_data[WIDTH-1], r_data[WIDTH-1:1]}
                                 : {r_data[WIDTH-2:0], 1'b0};
      default:    w_step = r_data;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: data register, step counter and latched job settings
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_rem  <= '0;
      r_dir  <= 1'b0;
      r_mode <= 2'b00;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (bus.p_load) begin
            r_data <= bus.p_data;
          end else if (bus.start) begin
            r_dir  <= bus.dir;
            r_mode <= bus.mode;
            r_rem  <= bus.amount;
          end
        end
        c_S_SHIFT: begin
          // Abort keeps the partial result but discards the outstanding count.
          if (bus.abort) begin
            r_rem <= '0;
          end else begin
            r_data <= w_step;
            r_rem  <= r_rem - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. In IDLE no job is latched, so s_out follows the live dir.
  // --------------------------------------------------------------------------
  assign w_dir_eff = (r_state == c_S_IDLE) ? bus.dir : r_dir;

  always_comb begin
    bus.p_out     = r_data;
    bus.remaining = r_rem;
    bus.busy      = (r_state == c_S_SHIFT);
    bus.done      = (r_state == c_S_DONE);
    bus.s_out     = w_dir_eff ? r_data[0] : r_data[WIDTH-1];
  end

endmodule
`default_nettype wire

// File: tb/tb_param_shift_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_shift_engine
// Purpose  : Self-checking bench for param_shift_engine (WIDTH=16, CNT_W=5).
//            Expected job results are queued at start; a monitor pops and
//            compares them whenever the engine pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_shift_engine;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  logic clk;
  logic reset;

  param_shift_engine_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  param_shift_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(bus.p_out), 32'hDEAD_BEEF);
        end else begin
          chk("done_p_out", 32'(bus.p_out), 32'(exp_q.pop_front()));
          chk("done_remaining", 32'(bus.remaining), 32'd0);
          chk("done_busy", 32'(bus.busy), 32'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    bus.p_load = 1'b1;
    bus.p_data = v;
    tick();
    bus.p_load = 1'b0;
  endtask

  task automatic issue(input logic d, input logic [1:0] m, input logic [CNT_W-1:0] amt,
                       input logic [WIDTH-1:0] expv);
    bus.start  = 1'b1;
    bus.dir    = d;
    bus.mode   = m;
    bus.amount = amt;
    exp_q.push_back(expv);
    tick();
    bus.start  = 1'b0;
  endtask

  // Waits for IDLE; returns busy-cycle count and s_out seen before each step.
  task automatic wait_idle(output int nbusy, output logic [31:0] sout_hist);
    int guard;
    nbusy     = 0;
    sout_hist = '0;
    guard     = 0;
    while ((bus.busy === 1'b1 || bus.done === 1'b1) && guard < 100) begin
      if (bus.busy === 1'b1) begin
        sout_hist[nbusy] = bus.s_out;
        nbusy++;
      end
      guard++;
      tick();
    end
    if (guard >= 100) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic job(input string name, input logic d, input logic [1:0] m,
                     input logic [CNT_W-1:0] amt, input logic [WIDTH-1:0] expv,
                     input int exp_busy);
    int nb;
    logic [31:0] h;
    issue(d, m, amt, expv);
    wait_idle(nb, h);
    chk({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
  endtask

  int nb;
  logic [31:0] hist;

  initial begin
    reset      = 1'b1;
    bus.p_load = 1'b0;
    bus.p_data = '0;
    bus.start  = 1'b0;
    bus.dir    = 1'b0;
    bus.mode   = 2'b00;
    bus.amount = '0;
    bus.s_in   = 1'b0;
    bus.abort  = 1'b0;
    tick();
    tick();
    chk("reset_p_out", 32'(bus.p_out), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_remaining", 32'(bus.remaining), 32'd0);
    chk("reset_s_out", 32'(bus.s_out), 32'd0);
    reset = 1'b0;
    tick();

    // Rotate right 4 of 0x8001; s_out (d[0]) before each step: 1,0,0,0
    load(16'h8001);
    issue(1'b1, 2'b01, 5'd4, 16'h1800);
    wait_idle(nb, hist);
    chk("rot_r4_busy_cycles", 32'(nb), 32'd4);
    chk("rot_r4_s_out_hist", hist, 32'b0001);
    chk("rot_r4_idle_p_out", 32'(bus.p_out), 32'h1800);

    // Arithmetic right 3
    load(16'h8000);
    job("ari_r3_neg", 1'b1, 2'b10, 5'd3, 16'hF000, 3);
    load(16'h4000);
    job("ari_r3_pos", 1'b1, 2'b10, 5'd3, 16'h0800, 3);

    // Logical left 4 with s_in=1; s_out (d[15]) before each step: all 0
    load(16'h00F0);
    bus.s_in = 1'b1;
    issue(1'b0, 2'b00, 5'd4, 16'h0F0F);
    wait_idle(nb, hist);
    chk("log_l4_busy_cycles", 32'(nb), 32'd4);
    chk("log_l4_s_out_hist", hist, 32'd0);

    // Logical right 3 with s_in=1 fills from the top
    load(16'h0000);
    job("log_r3_fill", 1'b1, 2'b00, 5'd3, 16'hE000, 3);
    bus.s_in = 1'b0;

    // Amount 0: done next cycle, data unchanged, never busy
    load(16'hABCD);
    job("amt0", 1'b1, 2'b01, 5'd0, 16'hABCD, 0);

    // Hold mode: counter runs, data held
    job("hold3", 1'b0, 2'b11, 5'd3, 16'hABCD, 3);

    // Arithmetic left zero-fills
    load(16'h8001);
    job("ari_l1", 1'b0, 2'b10, 5'd1, 16'h0002, 1);

    // p_load and start together: load wins, no job
    bus.p_load = 1'b1;
    bus.p_data = 16'h5555;
    bus.start  = 1'b1;
    bus.amount = 5'd2;
    tick();
    bus.p_load = 1'b0;
    bus.start  = 1'b0;
    chk("load_start_p_out", 32'(bus.p_out), 32'h5555);
    chk("load_start_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("load_start_done", 32'(bus.done), 32'd0);

    // s_out in IDLE follows the live dir
    bus.dir = 1'b0;
    #1;
    chk("idle_s_out_left", 32'(bus.s_out), 32'd0);
    bus.dir = 1'b1;
    #1;
    chk("idle_s_out_right", 32'(bus.s_out), 32'd1);

    // Abort after 2 steps of rotate-left 8; start/p_load during busy ignored
    load(16'h0001);
    bus.start  = 1'b1;
    bus.dir    = 1'b0;
    bus.mode   = 2'b01;
    bus.amount = 5'd8;
    tick();
    bus.p_load = 1'b1;
    bus.p_data = 16'hFFFF;
    bus.dir    = 1'b1;
    bus.mode   = 2'b00;
    tick();
    tick();
    bus.start  = 1'b0;
    bus.p_load = 1'b0;
    chk("abort_pre_p_out", 32'(bus.p_out), 32'h0004);
    chk("abort_pre_remaining", 32'(bus.remaining), 32'd6);
    chk("abort_pre_busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_p_out", 32'(bus.p_out), 32'h0004);
    chk("abort_remaining", 32'(bus.remaining), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    tick();
    chk("abort_done_later", 32'(bus.done), 32'd0);

    // Reset mid-job at remaining=3
    load(16'h1234);
    bus.start  = 1'b1;
    bus.dir    = 1'b0;
    bus.mode   = 2'b01;
    bus.amount = 5'd5;
    tick();
    bus.start  = 1'b0;
    tick();
    tick();
    chk("pre_reset_remaining", 32'(bus.remaining), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midjob_reset_p_out", 32'(bus.p_out), 32'd0);
    chk("midjob_reset_busy", 32'(bus.busy), 32'd0);
    chk("midjob_reset_done", 32'(bus.done), 32'd0);
    chk("midjob_reset_remaining", 32'(bus.remaining), 32'd0);
    tick();
    chk("post_reset_done", 32'(bus.done), 32'd0);

    // Amounts up to and beyond WIDTH
    load(16'h1234);
    job("rot_r16", 1'b1, 2'b01, 5'd16, 16'h1234, 16);
    load(16'hFFFF);
    job("log_l20_zero", 1'b0, 2'b00, 5'd20, 16'h0000, 20);

    // Back-to-back: start accepted in the cycle the engine returns to IDLE
    load(16'h0003);
    job("b2b_a", 1'b1, 2'b01, 5'd1, 16'h8001, 1);
    job("b2b_b", 1'b1, 2'b01, 5'd1, 16'hC000, 1);

    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
